pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Control-side counterpart of the pipeline registers: produces the stall/flush (clr) strobes that the
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers consume, plus E-stage forwarding selects. Detects load-use
//  and branch/jump hazards. Freezes the whole pipe while a multi-cycle data-memory access is outstanding.
// PARAMETERS
//  REG_AW       5    register address width
//  MEM_TIMEOUT  255  max WAIT cycles before forced release + error
//  CNT_W        32   width of the optional performance counters
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-low
//  rs1_d,rs2_d  in   REG_AW  D-stage source regs
//  rs1_e,rs2_e  in   REG_AW  E-stage source regs
//  rd_e         in   REG_AW  E-stage destination
//  resultsrc_e  in   2       E-stage result select (2'b01 = load)
//  pcsrc_e      in   1       branch taken or jump in E
//  rd_m,rd_w    in   REG_AW  M/W-stage destinations
//  regwrite_m   in   1       M-stage writes a register
//  regwrite_w   in   1       W-stage writes a register
//  dmem_req_m   in   1       M stage holds a load/store
//  dmem_ready   in   1       data memory completes the access this cycle
//  stall_f      out  1       hold PC
//  stall_d      out  1       hold IF/ID
//  stall_em     out  1       hold ID/EX and EX/MEM
//  flush_d      out  1       clear IF/ID
//  flush_e      out  1       clear ID/EX (its clr)
//  flush_w      out  1       clear MEM/WB (insert bubble)
//  fwd_a_e      out  2       00 regfile, 01 W result, 10 M ALU result
//  fwd_b_e      out  2       same encoding for operand B
//  mem_err      out  1       sticky: a memory access hit MEM_TIMEOUT
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, wait counter 0, mem_err 0. Stall/flush outputs 0, fwd 00.
//  - Forwarding (comb): fwd_a_e=10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
//    Else 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e. Else 00. M beats W. Same rule for B with rs2_e.
//  - lw_stall = resultsrc_e==2'b01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d). Holds exactly 1 cycle per load.
//  - Wait FSM, IDLE/WAIT:
//    IDLE->WAIT when dmem_req_m && !dmem_ready.
//    WAIT->IDLE when dmem_ready, or when counter reaches MEM_TIMEOUT (also sets mem_err).
//    Counter clears on entering WAIT. It counts only in WAIT. It saturates, never wraps.
//  - mem_wait = (IDLE && dmem_req_m && !dmem_ready) || (WAIT && !dmem_ready && !timeout). Combinational,
//    so the freeze starts the same cycle the miss is seen.
//  - mem_wait=1: stall_f=stall_d=stall_em=1, flush_w=1, flush_d=flush_e=0. Frozen E keeps pcsrc_e,
//    so the pending flush fires on the release cycle.
//  - mem_wait=0: stall_f=stall_d=lw_stall, stall_em=0, flush_w=0, flush_d=pcsrc_e, flush_e=lw_stall|pcsrc_e.
//  - dmem_ready and timeout in the same cycle: ready wins, mem_err is not set.
//  - mem_err is cleared only by reset.
//  - Reset mid-WAIT: returns to IDLE at once; all outputs go to their reset values.
// CONFIGURATION
//  - HAZARD_PERF_EN defined: adds outputs stall_cnt, flush_cnt (CNT_W each), reset to 0.
//    stall_cnt +1 per cycle with stall_f=1. flush_cnt +1 per cycle with flush_e=1. Both wrap modulo 2^CNT_W.
//  - HAZARD_PERF_EN undefined: no counter ports or logic.
// STRUCTURE
//  - pipe_pkg: fwd_sel_t enum (FWD_RF/FWD_W/FWD_M), RESULTSRC_LOAD=2'b01, wait_state_t enum (IDLE/WAIT).
//  - Sub-module dmem_wait_fsm: FSM, timeout counter, mem_err. Outputs mem_wait.
//  - Top level holds the forwarding logic, lw_stall, output muxing and the optional counters.
// TESTING
//  1. rd_m=5 regwrite_m=1, rd_w=5 regwrite_w=1, rs1_e=5 -> fwd_a_e=10. Same with rd_m=0 -> fwd_a_e=01.
//  2. resultsrc_e=01 rd_e=7 rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly one cycle. Repeat with rd_e=0 -> no stall.
//  3. pcsrc_e=1 in IDLE -> flush_d=flush_e=1 same cycle, stalls 0.
//  4. dmem_req_m=1, dmem_ready low 3 cycles -> stall_f/d/em and flush_w high those 3 cycles.
//     pcsrc_e=1 held during them -> flushes only on the 4th (ready) cycle.
//  5. MEM_TIMEOUT=4, ready never rises -> FSM leaves WAIT after 4 WAIT cycles, mem_err=1 and stays 1.
//     Ready on the timeout cycle -> mem_err stays 0.
//  6. Drop rst mid-WAIT -> all outputs 0 immediately, no clock edge needed.
//     HAZARD_PERF_EN: 3 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file value
    FWD_W  = 2'b01,  // W-stage result
    FWD_M  = 2'b10   // M-stage ALU result
  } fwd_sel_t;

  // resultsrc encoding that marks a load in flight.
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // Data-memory wait tracker states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_t;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Pipeline <-> hazard-controller signal bundle. The pipeline
//            (master) supplies stage register addresses and status, the
//            controller (slave) returns stall/flush strobes, forwarding
//            selects and the sticky memory error.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic [1:0]        resultsrc_e;
  logic              pcsrc_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_m;
  logic              regwrite_w;
  logic              dmem_req_m;
  logic              dmem_ready;

  logic              stall_f;
  logic              stall_d;
  logic              stall_em;
  logic              flush_d;
  logic              flush_e;
  logic              flush_w;
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic              mem_err;

  // Pipeline side.
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultsrc_e, pcsrc_e,
           rd_m, rd_w, regwrite_m, regwrite_w, dmem_req_m, dmem_ready,
    input  stall_f, stall_d, stall_em, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, mem_err
  );

  // Hazard controller side.
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultsrc_e, pcsrc_e,
           rd_m, rd_w, regwrite_m, regwrite_w, dmem_req_m, dmem_ready,
    output stall_f, stall_d, stall_em, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, mem_err
  );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_dmem_wait.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dmem_wait_fsm
// Brief    : Tracks an outstanding multi-cycle data-memory access. mem_wait
//            is combinational so the pipe freezes in the same cycle the miss
//            is seen. A WAIT that lasts MEM_TIMEOUT cycles without ready is
//            released by force and latches the sticky mem_err.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wait_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic dmem_req_m,
  input  logic dmem_ready,
  output logic mem_wait,
  output logic mem_err
);

  localparam int             c_CW   = $clog2(MEM_TIMEOUT + 1);
  // Timeout fires on the WAIT cycle that brings the count to MEM_TIMEOUT.
  localparam logic [c_CW-1:0] c_LAST = c_CW'(MEM_TIMEOUT - 1);
  localparam logic [c_CW-1:0] c_MAX  = c_CW'(MEM_TIMEOUT);

  wait_state_t     r_state;
  wait_state_t     w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic            r_err;
  logic            w_mem_wait;
  logic            w_timeout;
  logic            w_enter;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, freeze request and timeout detection.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_wait  = 1'b0;
    w_timeout   = 1'b0;
    w_enter     = 1'b0;
    case (r_state)
      IDLE: begin
        if (dmem_req_m && !dmem_ready) begin
          w_state_nxt = WAIT;
          w_mem_wait  = 1'b1;
          w_enter     = 1'b1;
        end
      end
      WAIT: begin
        w_timeout = (r_cnt == c_LAST);
        if (dmem_ready)     w_state_nxt = IDLE;
        else if (w_timeout) w_state_nxt = IDLE;
        else                w_mem_wait  = 1'b1;
      end
    endcase
  end

  // WAIT-cycle counter: cleared on entry, counts only in WAIT, saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (w_enter)
      r_cnt <= '0;
    else if (r_state == WAIT && r_cnt != c_MAX)
      r_cnt <= r_cnt + c_CW'(1);
  end

  // Sticky error: only a forced release sets it; ready on that cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (r_state == WAIT && w_timeout && !dmem_ready)
      r_err <= 1'b1;
  end

  assign mem_wait = w_mem_wait;
  assign mem_err  = r_err;

endmodule : dmem_wait_fsm
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline hazard controller. Generates E-stage forwarding
//            selects, load-use stalls, branch/jump flushes and a full-pipe
//            freeze while a data-memory access is outstanding.
//            Optional macro HAZARD_PERF_EN adds stall_cnt / flush_cnt
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,        // asynchronous, active-low
  pipe_hazard_ctrl_if.slave       hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
`endif
);

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_lw_stall;
  logic     w_mem_wait;
  logic     w_stall_f;
  logic     w_stall_d;
  logic     w_stall_em;
  logic     w_flush_d;
  logic     w_flush_e;
  logic     w_flush_w;

  dmem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_dmem_wait (
    .clk        (clk),
    .rst        (rst),
    .dmem_req_m (hz.dmem_req_m),
    .dmem_ready (hz.dmem_ready),
    .mem_wait   (w_mem_wait),
    .mem_err    (hz.mem_err)
  );

  // Forwarding selects: the younger M-stage result beats the W-stage one.
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (hz.regwrite_m && hz.rd_m != '0 && hz.rd_m == hz.rs1_e)
      w_fwd_a = FWD_M;
    else if (hz.regwrite_w && hz.rd_w != '0 && hz.rd_w == hz.rs1_e)
      w_fwd_a = FWD_W;
    if (hz.regwrite_m && hz.rd_m != '0 && hz.rd_m == hz.rs2_e)
      w_fwd_b = FWD_M;
    else if (hz.regwrite_w && hz.rd_w != '0 && hz.rd_w == hz.rs2_e)
      w_fwd_b = FWD_W;
  end

  // Load in E whose destination is read by the instruction in D.
  assign w_lw_stall = (hz.resultsrc_e == RESULTSRC_LOAD) && (hz.rd_e != '0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // Stall/flush muxing; a memory freeze overrides everything and defers
  // any branch flush to the release cycle. Reset forces every strobe low.
  always_comb begin
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_em = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_flush_w  = 1'b0;
    if (rst) begin
      if (w_mem_wait) begin
        w_stall_f  = 1'b1;
        w_stall_d  = 1'b1;
        w_stall_em = 1'b1;
        w_flush_w  = 1'b1;
      end else begin
        w_stall_f  = w_lw_stall;
        w_stall_d  = w_lw_stall;
        w_flush_d  = hz.pcsrc_e;
        w_flush_e  = w_lw_stall | hz.pcsrc_e;
      end
    end
  end

  assign hz.stall_f  = w_stall_f;
  assign hz.stall_d  = w_stall_d;
  assign hz.stall_em = w_stall_em;
  assign hz.flush_d  = w_flush_d;
  assign hz.flush_e  = w_flush_e;
  assign hz.flush_w  = w_flush_w;
  assign hz.fwd_a_e  = rst ? w_fwd_a : FWD_RF;
  assign hz.fwd_b_e  = rst ? w_fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Performance counters: free-running, wrap modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_e) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
//            Directed scenarios followed by random traffic, all compared
//            against a behavioural model of the hazard rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  bit m_in_wait;   // an access is outstanding
  int m_waited;    // WAIT cycles already spent without ready
  bit m_err;
  int m_stalls;
  int m_flushes;
  bit e_stall_f;
  bit e_flush_e;

  function automatic logic [1:0] model_fwd(input logic rw_m, input logic [4:0] rd_m,
                                           input logic rw_w, input logic [4:0] rd_w,
                                           input logic [4:0] rs);
    if (rw_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rw_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_in_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    hz.rs1_d = 0; hz.rs2_d = 0; hz.rs1_e = 0; hz.rs2_e = 0; hz.rd_e = 0;
    hz.resultsrc_e = 0; hz.pcsrc_e = 0; hz.rd_m = 0; hz.rd_w = 0;
    hz.regwrite_m = 0; hz.regwrite_w = 0; hz.dmem_req_m = 0; hz.dmem_ready = 0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_all();
    bit lw, frozen;
    lw = (hz.resultsrc_e == 2'b01) && (hz.rd_e != 0) &&
         (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    if (m_in_wait) frozen = !hz.dmem_ready && (m_waited + 1 < TO);
    else           frozen = hz.dmem_req_m && !hz.dmem_ready;
    e_stall_f = frozen ? 1'b1 : lw;
    e_flush_e = frozen ? 1'b0 : (lw | hz.pcsrc_e);
    chk("fwd_a",    32'(hz.fwd_a_e),  32'(model_fwd(hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w, hz.rs1_e)));
    chk("fwd_b",    32'(hz.fwd_b_e),  32'(model_fwd(hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w, hz.rs2_e)));
    chk("stall_f",  32'(hz.stall_f),  32'(e_stall_f));
    chk("stall_d",  32'(hz.stall_d),  32'(e_stall_f));
    chk("stall_em", 32'(hz.stall_em), 32'(frozen));
    chk("flush_w",  32'(hz.flush_w),  32'(frozen));
    chk("flush_d",  32'(hz.flush_d),  32'(!frozen && hz.pcsrc_e));
    chk("flush_e",  32'(hz.flush_e),  32'(e_flush_e));
    chk("mem_err",  32'(hz.mem_err),  32'(m_err));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 32'(m_stalls));
    chk("flush_cnt", flush_cnt, 32'(m_flushes));
`endif
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    if (e_stall_f) m_stalls++;
    if (e_flush_e) m_flushes++;
    if (!m_in_wait) begin
      if (hz.dmem_req_m && !hz.dmem_ready) begin m_in_wait = 1; m_waited = 0; end
    end else if (hz.dmem_ready) begin
      m_in_wait = 0;
    end else if (m_waited + 1 >= TO) begin
      m_in_wait = 0; m_err = 1;
    end else begin
      m_waited++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stall_f"},  32'(hz.stall_f),  0);
    chk({tag, "_stall_d"},  32'(hz.stall_d),  0);
    chk({tag, "_stall_em"}, 32'(hz.stall_em), 0);
    chk({tag, "_flush_d"},  32'(hz.flush_d),  0);
    chk({tag, "_flush_e"},  32'(hz.flush_e),  0);
    chk({tag, "_flush_w"},  32'(hz.flush_w),  0);
    chk({tag, "_fwd_a"},    32'(hz.fwd_a_e),  0);
    chk({tag, "_fwd_b"},    32'(hz.fwd_b_e),  0);
    chk({tag, "_mem_err"},  32'(hz.mem_err),  0);
`ifdef HAZARD_PERF_EN
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
`endif
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    model_reset();
    idle_inputs();

    // Reset with active hazard inputs: everything must read as zero.
    rst = 1'b0;
    hz.regwrite_m = 1; hz.rd_m = 3; hz.rs1_e = 3; hz.rs2_e = 3; hz.pcsrc_e = 1;
    #1;
    all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // 1: M/W both match -> M wins; rd_m = 0 -> W.
    hz.regwrite_m = 1; hz.rd_m = 5; hz.regwrite_w = 1; hz.rd_w = 5;
    hz.rs1_e = 5; hz.rs2_e = 5;
    sample(); chk("t1_fwd_a_m", 32'(hz.fwd_a_e), 2); advance();
    hz.rd_m = 0;
    sample(); chk("t1_fwd_a_w", 32'(hz.fwd_a_e), 1); chk("t1_fwd_b_w", 32'(hz.fwd_b_e), 1); advance();
    idle_inputs();

    // 2: load-use stall for one cycle, then the E bubble; rd_e = 0 never stalls.
    hz.resultsrc_e = 2'b01; hz.rd_e = 7; hz.rs2_d = 7;
    sample();
    chk("t2_stall_f", 32'(hz.stall_f), 1); chk("t2_stall_d", 32'(hz.stall_d), 1);
    chk("t2_flush_e", 32'(hz.flush_e), 1);
    advance();
    hz.resultsrc_e = 0; hz.rd_e = 0;
    sample(); chk("t2_bubble_stall", 32'(hz.stall_f), 0); advance();
    hz.resultsrc_e = 2'b01; hz.rd_e = 0; hz.rs1_d = 0; hz.rs2_d = 0;
    sample(); chk("t2_x0_stall", 32'(hz.stall_f), 0); advance();
    idle_inputs();

    // 3: taken branch flushes D and E, no stall.
    hz.pcsrc_e = 1;
    sample();
    chk("t3_flush_d", 32'(hz.flush_d), 1); chk("t3_flush_e", 32'(hz.flush_e), 1);
    chk("t3_stall_f", 32'(hz.stall_f), 0);
    advance();

    // 4: three miss cycles with a pending branch, flush only on ready.
    hz.dmem_req_m = 1; hz.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t4_stall_em", 32'(hz.stall_em), 1); chk("t4_flush_w", 32'(hz.flush_w), 1);
      chk("t4_flush_d", 32'(hz.flush_d), 0);
      advance();
    end
    hz.dmem_ready = 1;
    sample();
    chk("t4_rel_flush_d", 32'(hz.flush_d), 1); chk("t4_rel_stall_em", 32'(hz.stall_em), 0);
    advance();
    idle_inputs();

    // 5: ready never rises -> forced release after TO WAIT cycles, sticky error.
    hz.dmem_req_m = 1;
    for (int i = 0; i < TO; i++) begin
      sample(); chk("t5_frozen", 32'(hz.stall_em), 1); advance();
    end
    sample(); chk("t5_release", 32'(hz.stall_em), 0); advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      sample(); chk("t5_err_sticky", 32'(hz.mem_err), 1); advance();
    end

    rst = 1'b0; #2; rst = 1'b1;
    model_reset();

    // 5b: ready on the timeout cycle wins, no error.
    hz.dmem_req_m = 1;
    for (int i = 0; i < TO; i++) begin
      sample(); advance();
    end
    hz.dmem_ready = 1;
    sample(); advance();
    idle_inputs();
    sample(); chk("t5b_no_err", 32'(hz.mem_err), 0); advance();

    // 6: asynchronous reset in the middle of WAIT.
    hz.dmem_req_m = 1; hz.pcsrc_e = 1; hz.regwrite_m = 1; hz.rd_m = 9; hz.rs1_e = 9;
    sample(); advance();
    sample(); advance();
    #2;
    rst = 1'b0;
    #1;
    all_zero("t6_async");
    model_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;

`ifdef HAZARD_PERF_EN
    // Three load-use stall cycles.
    hz.resultsrc_e = 2'b01; hz.rd_e = 4; hz.rs1_d = 4;
    for (int i = 0; i < 3; i++) begin
      sample(); advance();
    end
    idle_inputs();
    sample(); chk("perf_stall3", stall_cnt, 3); advance();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      hz.rs1_d       = 5'($urandom_range(0, 3));
      hz.rs2_d       = 5'($urandom_range(0, 3));
      hz.rs1_e       = 5'($urandom_range(0, 3));
      hz.rs2_e       = 5'($urandom_range(0, 3));
      hz.rd_e        = 5'($urandom_range(0, 3));
      hz.rd_m        = 5'($urandom_range(0, 3));
      hz.rd_w        = 5'($urandom_range(0, 3));
      hz.resultsrc_e = 2'($urandom_range(0, 3));
      hz.pcsrc_e     = 1'($urandom_range(0, 3) == 0);
      hz.regwrite_m  = 1'($urandom_range(0, 1));
      hz.regwrite_w  = 1'($urandom_range(0, 1));
      hz.dmem_req_m  = 1'($urandom_range(0, 1));
      hz.dmem_ready  = 1'($urandom_range(0, 4) < 2);
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
